// File: rtl/mda_motor_control_pwm_decode_pkg.sv
// mda_motor_control_pwm_decode_pkg: decoder FSM states and motor state encodings
package mda_motor_control_pwm_decode_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_STATIC} state_t;
    localparam logic [1:0] MOTOR_DRIFT = 2'd0;
    localparam logic [1:0] MOTOR_BRAKE = 2'd1;
    localparam logic [1:0] MOTOR_FWD   = 2'd2;
    localparam logic [1:0] MOTOR_REV   = 2'd3;
    function automatic logic [1:0] level_state(input logic on, input logic dir);
        return on ? (dir ? MOTOR_FWD : MOTOR_REV) : (dir ? MOTOR_BRAKE : MOTOR_DRIFT);
    endfunction
endpackage

// File: rtl/mda_sync2.sv
// mda_sync2: two-flop synchronizer with async active-high reset
module mda_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/mda_motor_control_pwm_decode.sv
// mda_motor_control_pwm_decode: recovers period, signed-about-50% duty and motor state
// from the H-bridge dir/on lines of one motor channel.
module mda_motor_control_pwm_decode
    import mda_motor_control_pwm_decode_pkg::*;
#(
    parameter int                       PERIOD_LENGTH = 16,
    parameter logic [PERIOD_LENGTH-1:0] TIMEOUT       = {PERIOD_LENGTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dir_in,
    input  logic                     on_in,
    output logic [PERIOD_LENGTH-1:0] period_out,
    output logic [PERIOD_LENGTH-1:0] duty_cycle_out,
    output logic [1:0]               motor_state,
    output logic                     valid,
    output logic                     update,
    output logic                     timeout_flag
);
    localparam int W = PERIOD_LENGTH;

    logic [1:0]   w_sync;
    logic         w_on_s, w_dir_s, w_rise, w_tmo;
    logic         r_on_d, r_dir_lat;
    state_t       r_state;
    logic [W-1:0] r_per_cnt, r_on_cnt;
    logic [W-1:0] w_per_inc, w_on_inc, w_p, w_h, w_k;
    logic [W-1:0] w_fwd_duty, w_rev_duty, w_lvl_duty;
    logic [W:0]   w_sum;
    logic [1:0]   w_lvl_state;

    mda_sync2 #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({dir_in, on_in}),
        .o_q   (w_sync)
    );

    assign w_on_s      = w_sync[0];
    assign w_dir_s     = w_sync[1];
    assign w_rise      = w_on_s & ~r_on_d;
    assign w_tmo       = r_per_cnt == TIMEOUT;
    assign w_per_inc   = r_per_cnt + W'(~&r_per_cnt);
    assign w_on_inc    = r_on_cnt + W'(~&r_on_cnt);
    // Duty is H offset by half the on-time: forward adds, reverse subtracts.
    assign w_p         = r_per_cnt - W'(1);
    assign w_h         = w_p >> 1;
    assign w_k         = r_on_cnt >> 1;
    assign w_sum       = {1'b0, w_h} + {1'b0, w_k};
    assign w_fwd_duty  = (w_sum > {1'b0, w_p}) ? w_p : w_sum[W-1:0];
    assign w_rev_duty  = (w_h > w_k) ? w_h - w_k : '0;
    assign w_lvl_state = level_state(w_on_s, w_dir_s);
    assign w_lvl_duty  = w_on_s ? (w_dir_s ? period_out : '0) : period_out >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_on_d         <= 1'b0;
            r_dir_lat      <= 1'b0;
            r_state        <= S_IDLE;
            r_per_cnt      <= '0;
            r_on_cnt       <= '0;
            period_out     <= '0;
            duty_cycle_out <= '0;
            motor_state    <= MOTOR_DRIFT;
            valid          <= 1'b0;
            update         <= 1'b0;
            timeout_flag   <= 1'b0;
        end else begin
            r_on_d    <= w_on_s;
            update    <= 1'b0;
            r_per_cnt <= w_per_inc;
            r_on_cnt  <= w_on_s ? w_on_inc : r_on_cnt;
            if (w_rise) begin
                r_per_cnt    <= W'(1);
                r_on_cnt     <= W'(1);
                r_dir_lat    <= w_dir_s;
                r_state      <= S_MEASURE;
                timeout_flag <= 1'b0;
                if (r_state == S_MEASURE) begin
                    period_out     <= w_p;
                    duty_cycle_out <= r_dir_lat ? w_fwd_duty : w_rev_duty;
                    motor_state    <= r_dir_lat ? MOTOR_FWD : MOTOR_REV;
                    update         <= 1'b1;
                    valid          <= 1'b1;
                end
            end else if (r_state != S_STATIC && w_tmo) begin
                r_state        <= S_STATIC;
                timeout_flag   <= 1'b1;
                valid          <= 1'b1;
                update         <= 1'b1;
                motor_state    <= w_lvl_state;
                duty_cycle_out <= w_lvl_duty;
            end else if (r_state == S_STATIC && w_lvl_state != motor_state) begin
                update         <= 1'b1;
                motor_state    <= w_lvl_state;
                duty_cycle_out <= w_lvl_duty;
            end
        end
    end
endmodule

// File: tb/tb_mda_motor_control_pwm_decode.sv
// tb_mda_motor_control_pwm_decode: directed PWM/level stimulus with an update-driven scoreboard
module tb_mda_motor_control_pwm_decode;
    localparam int TMO = 2000;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] d;
        logic [1:0]  s;
        logic        t;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, dir_in = 1'b0, on_in = 1'b0;
    logic [15:0] period_out, duty_cycle_out;
    logic [1:0]  motor_state;
    logic        valid, update, timeout_flag;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0, n_bad = 0;
    logic have_prev = 1'b0;
    int   prev_p = 0, prev_d = 0;

    mda_motor_control_pwm_decode #(.PERIOD_LENGTH(16), .TIMEOUT(16'(TMO))) dut (
        .clk            (clk),
        .reset          (reset),
        .dir_in         (dir_in),
        .on_in          (on_in),
        .period_out     (period_out),
        .duty_cycle_out (duty_cycle_out),
        .motor_state    (motor_state),
        .valid          (valid),
        .update         (update),
        .timeout_flag   (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input int p, input int d, input int s, input int t);
        exp_t e;
        e.p = 16'(p);
        e.d = 16'(d);
        e.s = 2'(s);
        e.t = 1'(t);
        q.push_back(e);
    endtask

    // Generator model: on-time = 2*|duty - P/2|, dir high when duty is above half.
    task automatic pwm(input int p, input int d, input int n);
        int h;
        int t;
        h = p / 2;
        t = (d > h) ? 2 * (d - h) : 2 * (h - d);
        for (int i = 0; i < n; i++) begin
            if (have_prev) push(prev_p, prev_d, (prev_d > prev_p / 2) ? 2 : 3, 0);
            have_prev = 1'b1;
            prev_p = p;
            prev_d = d;
            for (int c = 0; c <= p; c++) begin
                @(negedge clk);
                on_in  = (c < t);
                dir_in = (d > h);
            end
        end
    endtask

    task automatic lvl(input logic dr, input logic on, input int cyc,
                       input int ps, input int pd, input int st, input logic do_push);
        if (do_push) push(ps, pd, st, 1);
        have_prev = 1'b0;
        @(negedge clk);
        dir_in = dr;
        on_in  = on;
        repeat (cyc - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && update) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_update: got p=%0d d=%0d s=%0d want no update",
                         period_out, duty_cycle_out, motor_state);
            end else begin
                m_e = q.pop_front();
                chk("update_p_d_s_tf_v",
                    {period_out, duty_cycle_out, motor_state, timeout_flag, valid},
                    {m_e.p, m_e.d, m_e.s, m_e.t, 1'b1});
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {period_out, duty_cycle_out, motor_state, valid, update, timeout_flag}, 0);
        reset = 1'b0;
        pwm(999, 750, 4);
        pwm(999, 250, 3);
        pwm(999, 0, 2);
        lvl(1'b0, 1'b0, 1500, 999, 499, 0, 1'b1);
        lvl(1'b1, 1'b0, 100, 999, 499, 1, 1'b1);
        lvl(1'b1, 1'b1, TMO + 100, 999, 999, 2, 1'b1);
        lvl(1'b0, 1'b1, 100, 999, 0, 3, 1'b1);
        lvl(1'b0, 1'b0, 100, 999, 499, 0, 1'b1);
        lvl(1'b0, 1'b1, 1, 0, 0, 0, 1'b0);
        lvl(1'b0, 1'b0, TMO + 500, 999, 499, 0, 1'b1);
        pwm(999, 750, 2);
        @(negedge clk);
        reset = 1'b1;
        on_in = 1'b0;
        dir_in = 1'b0;
        have_prev = 1'b0;
        #1;
        chk("mid_reset_outputs", {period_out, duty_cycle_out, motor_state, valid, update, timeout_flag}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pwm(999, 300, 3);
        lvl(1'b1, 1'b0, TMO + 500, 999, 499, 1, 1'b1);
        pwm(399, 100, 3);
        lvl(1'b0, 1'b0, 20, 0, 0, 0, 1'b0);
        repeat (10) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
